// File: rtl/dual_ram_pipe_if.sv
// dual_ram_pipe_if: request/response bundle for the dual_ram_pipe RAM.
// master drives writes, reads and clear requests; slave (the RAM) returns
// ready, registered read data and the read-valid strobe.
interface dual_ram_pipe_if #(
    parameter int DATA_SIZE = 16,
    parameter int ADDR_SIZE = 8
);
    localparam int NLANE = DATA_SIZE / 8;

    logic                 clear;
    logic                 ready;
    logic                 wen;
    logic [ADDR_SIZE-1:0] waddr;
    logic [DATA_SIZE-1:0] wdata;
    logic [NLANE-1:0]     wbe;
    logic                 ren;
    logic [ADDR_SIZE-1:0] raddr;
    logic [DATA_SIZE-1:0] rdata;
    logic                 rvalid;

    modport master (
        output clear, wen, waddr, wdata, wbe, ren, raddr,
        input  ready, rdata, rvalid
    );

    modport slave (
        input  clear, wen, waddr, wdata, wbe, ren, raddr,
        output ready, rdata, rvalid
    );
endinterface

// File: rtl/dual_ram_pipe.sv
// dual_ram_pipe: single-clock RAM, one write port plus one registered read
// port, per-byte write enables, read-valid strobe and a clear sequencer that
// sweeps CLEAR_VALUE into every word after reset or on request.
//
// Build option: define DUAL_RAM_PIPE_BYPASS_EN to return the freshly written
// bytes on a same-address read/write in one cycle (new-data). Without it a
// colliding read returns the pre-write contents (old-data). Memory contents
// after the edge are the same either way.

// One byte lane: its own storage column plus its byte of the read register.
module dual_ram_pipe_lane #(
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_we,
    input  logic [ADDR_SIZE-1:0] i_waddr,
    input  logic [7:0]           i_wdata,
    input  logic                 i_re,
    input  logic [ADDR_SIZE-1:0] i_raddr,
    output logic [7:0]           o_rdata
);
    localparam int DEPTH = 1 << ADDR_SIZE;

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rdata;
    logic [7:0] w_rd_byte;

    // Storage column; intentionally not reset, the clear sweep initialises it.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

`ifdef DUAL_RAM_PIPE_BYPASS_EN
    // Read source: forward this lane's write byte on an address collision.
    always_comb begin
        w_rd_byte = r_mem[i_raddr];
        if (i_we && (i_waddr == i_raddr)) w_rd_byte = i_wdata;
    end
`else
    // Read source: array contents as they stand before this edge's write.
    always_comb begin
        w_rd_byte = r_mem[i_raddr];
    end
`endif

    // Registered read byte; holds its value when no read is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    r_rdata <= '0;
        else if (i_re) r_rdata <= w_rd_byte;
    end

    assign o_rdata = r_rdata;
endmodule

module dual_ram_pipe #(
    parameter int                   DATA_SIZE   = 16,
    parameter int                   ADDR_SIZE   = 8,
    parameter logic [DATA_SIZE-1:0] CLEAR_VALUE = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    dual_ram_pipe_if.slave bus
);
    localparam int                   NLANE     = DATA_SIZE / 8;
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = '1;

    typedef enum logic {S_CLEAR = 1'b0, S_READY = 1'b1} state_t;

    // Write request as seen by the lanes: either the sweep or the user port.
    typedef struct packed {
        logic                  en;
        logic [ADDR_SIZE-1:0]  addr;
        logic [NLANE-1:0][7:0] data;
        logic [NLANE-1:0]      be;
    } wr_req_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_SIZE-1:0]  r_clr_addr;
    logic [ADDR_SIZE-1:0]  w_clr_addr_nxt;
    logic                  r_ready;
    logic                  r_rvalid;
    logic                  w_rd_en;
    wr_req_t               w_wr;
    logic [NLANE-1:0][7:0] w_rdata;

    // FSM state, sweep pointer and the registered ready/rvalid outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= '0;
            r_ready    <= 1'b0;
            r_rvalid   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
            r_ready    <= (w_state_nxt == S_READY);
            r_rvalid   <= w_rd_en;
        end
    end

    // Next state plus write/read steering. In CLEAR the user port is ignored
    // and the sweep owns the write port; the last sweep write hands over to
    // READY. A clear request in READY still lets that cycle's ops complete.
    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        w_rd_en        = 1'b0;
        w_wr           = '0;
        case (r_state)
            S_CLEAR: begin
                w_wr.en        = 1'b1;
                w_wr.addr      = r_clr_addr;
                w_wr.data      = CLEAR_VALUE;
                w_wr.be        = '1;
                w_clr_addr_nxt = r_clr_addr + 1'b1;
                if (r_clr_addr == LAST_ADDR) w_state_nxt = S_READY;
            end
            S_READY: begin
                w_wr.en   = bus.wen;
                w_wr.addr = bus.waddr;
                w_wr.data = bus.wdata;
                w_wr.be   = bus.wbe;
                w_rd_en   = bus.ren;
                if (bus.clear) begin
                    w_state_nxt    = S_CLEAR;
                    w_clr_addr_nxt = '0;
                end
            end
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    // One storage lane per byte; a lane writes only when its enable is set.
    for (genvar g = 0; g < NLANE; g++) begin : g_lane
        dual_ram_pipe_lane #(
            .ADDR_SIZE (ADDR_SIZE)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_we    (w_wr.en & w_wr.be[g]),
            .i_waddr (w_wr.addr),
            .i_wdata (w_wr.data[g]),
            .i_re    (w_rd_en),
            .i_raddr (bus.raddr),
            .o_rdata (w_rdata[g])
        );
    end

    assign bus.ready  = r_ready;
    assign bus.rvalid = r_rvalid;
    assign bus.rdata  = w_rdata;
endmodule

// File: tb/tb_dual_ram_pipe.sv
// tb_dual_ram_pipe: randomized + directed bench for dual_ram_pipe with
// DEPTH=16, 16-bit words. Expected data comes from a word-array model.
module tb_dual_ram_pipe;
    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    logic [15:0] mdl_mem [DEPTH];
    logic [15:0] mdl_rdata;

    dual_ram_pipe_if #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) bus();

    dual_ram_pipe #(
        .DATA_SIZE   (DW),
        .ADDR_SIZE   (AW),
        .CLEAR_VALUE (16'h0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wen = 1'b0; bus.ren = 1'b0; bus.clear = 1'b0;
        bus.wbe = 2'b00; bus.waddr = '0; bus.raddr = '0; bus.wdata = '0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 16'h0000;
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old_w,
                                          input logic [15:0] new_w,
                                          input logic [1:0]  be);
        logic [15:0] r;
        r = old_w;
        if (be[0]) r[7:0]  = new_w[7:0];
        if (be[1]) r[15:8] = new_w[15:8];
        return r;
    endfunction

    // One READY-state cycle: update the model, drive the port, take one edge.
    task automatic op(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                      input logic [1:0] be, input logic re, input logic [3:0] ra,
                      input logic clr);
        logic [15:0] rd;
        rd = mdl_mem[ra];
`ifdef DUAL_RAM_PIPE_BYPASS_EN
        if (we && wa == ra) rd = merge(rd, wd, be);
`endif
        if (re) mdl_rdata = rd;
        if (we) mdl_mem[wa] = merge(mdl_mem[wa], wd, be);
        bus.wen = we; bus.waddr = wa; bus.wdata = wd; bus.wbe = be;
        bus.ren = re; bus.raddr = ra; bus.clear = clr;
        step();
        idle();
    endtask

    // Counts edges until ready rises, bounded so a stuck DUT cannot hang.
    task automatic edges_to_ready(output int edges);
        edges = 0;
        while (!bus.ready && edges < 40) begin
            step();
            edges++;
        end
    endtask

    task automatic test_reset();
        int e;
        logic [15:0] g;
        idle();
        #2;
        n_total++; if (bus.ready !== 1'b0 || bus.rvalid !== 1'b0 || bus.rdata !== 16'h0)
            $display("FAIL reset_state: ready=%b rvalid=%b rdata=%h want 0 0 0000", bus.ready, bus.rvalid, bus.rdata);
            else n_pass++;
        @(posedge clk); #1; rst_n = 1'b1;
        edges_to_ready(e);
        n_total++; if (e !== 16) $display("FAIL first_sweep_len: ready after %0d edges want 16", e); else n_pass++;
        model_clear();
        // Preload garbage, then reset again so the sweep must overwrite it.
        for (int a = 0; a < DEPTH; a++) begin
            g = 16'($urandom) | 16'h0101;
            op(1'b1, 4'(a), g, 2'b11, 1'b0, 4'd0, 1'b0);
        end
        op(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd7, 1'b0);
        n_total++; if (bus.rdata !== mdl_rdata) $display("FAIL garbage_read: rdata=%h want %h", bus.rdata, mdl_rdata); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (bus.ready !== 1'b0 || bus.rvalid !== 1'b0 || bus.rdata !== 16'h0)
            $display("FAIL async_reset: ready=%b rvalid=%b rdata=%h want 0 0 0000", bus.ready, bus.rvalid, bus.rdata);
            else n_pass++;
        @(posedge clk); #1; rst_n = 1'b1;
        edges_to_ready(e);
        n_total++; if (e !== 16) $display("FAIL sweep_len: ready after %0d edges want 16", e); else n_pass++;
        model_clear();
        op(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd9, 1'b0);
        n_total++; if (bus.rvalid !== 1'b1 || bus.rdata !== 16'h0000)
            $display("FAIL read_after_clear: rvalid=%b rdata=%h want 1 0000", bus.rvalid, bus.rdata); else n_pass++;
        step();
        n_total++; if (bus.rvalid !== 1'b0) $display("FAIL rvalid_pulse: rvalid=%b want 0", bus.rvalid); else n_pass++;
    endtask

    task automatic test_write_read();
        op(1'b1, 4'd3, 16'hA5C3, 2'b11, 1'b0, 4'd0, 1'b0);
        op(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd3, 1'b0);
        n_total++; if (bus.rvalid !== 1'b1 || bus.rdata !== 16'hA5C3)
            $display("FAIL write_read: rvalid=%b rdata=%h want 1 a5c3", bus.rvalid, bus.rdata); else n_pass++;
        step();
        n_total++; if (bus.rvalid !== 1'b0 || bus.rdata !== 16'hA5C3)
            $display("FAIL rdata_hold: rvalid=%b rdata=%h want 0 a5c3", bus.rvalid, bus.rdata); else n_pass++;
    endtask

    task automatic test_byte_enable();
        op(1'b1, 4'd3, 16'h00FF, 2'b01, 1'b0, 4'd0, 1'b0);
        op(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd3, 1'b0);
        n_total++; if (bus.rdata !== 16'hA5FF) $display("FAIL lane0_write: rdata=%h want a5ff", bus.rdata); else n_pass++;
        op(1'b1, 4'd3, 16'hFFFF, 2'b00, 1'b0, 4'd0, 1'b0);
        op(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd3, 1'b0);
        n_total++; if (bus.rdata !== 16'hA5FF) $display("FAIL wbe_zero_noop: rdata=%h want a5ff", bus.rdata); else n_pass++;
    endtask

    task automatic test_same_addr();
        logic [15:0] want;
`ifdef DUAL_RAM_PIPE_BYPASS_EN
        want = 16'h12FF;
`else
        want = 16'hA5FF;
`endif
        op(1'b1, 4'd3, 16'h1234, 2'b10, 1'b1, 4'd3, 1'b0);
        n_total++; if (bus.rvalid !== 1'b1 || bus.rdata !== want)
            $display("FAIL collide_read: rvalid=%b rdata=%h want 1 %h", bus.rvalid, bus.rdata, want); else n_pass++;
        op(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd3, 1'b0);
        n_total++; if (bus.rdata !== 16'h12FF) $display("FAIL collide_after: rdata=%h want 12ff", bus.rdata); else n_pass++;
    endtask

    task automatic test_clear();
        int bad_v, bad_r, bad_d, e;
        op(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd3, 1'b1);
        n_total++; if (bus.rvalid !== 1'b1 || bus.rdata !== 16'h12FF || bus.ready !== 1'b0)
            $display("FAIL clear_edge: rvalid=%b rdata=%h ready=%b want 1 12ff 0", bus.rvalid, bus.rdata, bus.ready); else n_pass++;
        model_clear();
        bad_v = 0; bad_r = 0; bad_d = 0; e = 0;
        // Hammer the port during the sweep; everything must be ignored,
        // including repeated clear requests.
        for (int k = 1; k <= 16; k++) begin
            bus.wen = 1'b1; bus.waddr = 4'($urandom); bus.wdata = 16'($urandom) | 16'h8001;
            bus.wbe = 2'b11; bus.ren = 1'b1; bus.raddr = 4'($urandom); bus.clear = (k < 8);
            step();
            if (bus.rvalid !== 1'b0) bad_v++;
            if (bus.ready !== (k == 16)) bad_r++;
            if (bus.rdata !== 16'h12FF) bad_d++;
        end
        idle();
        n_total++; if (bad_v != 0) $display("FAIL sweep_rvalid: %0d cycles with rvalid=1 want 0", bad_v); else n_pass++;
        n_total++; if (bad_r != 0) $display("FAIL sweep_ready: %0d cycles ready wrong want rise at 16", bad_r); else n_pass++;
        n_total++; if (bad_d != 0) $display("FAIL sweep_rdata: %0d cycles rdata changed want 12ff", bad_d); else n_pass++;
        for (int a = 0; a < DEPTH; a++) begin
            op(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'(a), 1'b0);
            if (bus.rdata !== mdl_mem[a]) e++;
        end
        n_total++; if (e != 0) $display("FAIL cleared_contents: %0d words nonzero want 0", e); else n_pass++;
    endtask

    task automatic test_reset_mid_sweep();
        int e;
        op(1'b1, 4'd5, 16'hBEEF, 2'b11, 1'b0, 4'd0, 1'b0);
        op(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd5, 1'b1);
        n_total++; if (bus.rdata !== 16'hBEEF) $display("FAIL pre_reset_read: rdata=%h want beef", bus.rdata); else n_pass++;
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        n_total++; if (bus.ready !== 1'b0 || bus.rvalid !== 1'b0 || bus.rdata !== 16'h0)
            $display("FAIL mid_sweep_reset: ready=%b rvalid=%b rdata=%h want 0 0 0000", bus.ready, bus.rvalid, bus.rdata); else n_pass++;
        @(posedge clk); #1; rst_n = 1'b1;
        edges_to_ready(e);
        n_total++; if (e !== 16) $display("FAIL restart_sweep_len: ready after %0d edges want 16", e); else n_pass++;
        model_clear();
        op(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd5, 1'b0);
        n_total++; if (bus.rdata !== 16'h0000) $display("FAIL restart_contents: rdata=%h want 0000", bus.rdata); else n_pass++;
    endtask

    task automatic test_random();
        logic we, re;
        logic [3:0] wa, ra;
        logic [15:0] wd;
        logic [1:0] be;
        int bad_v, bad_d;
        bad_v = 0; bad_d = 0;
        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom); re = 1'($urandom);
            wa = 4'($urandom_range(0, 3)); ra = 4'($urandom_range(0, 3));
            wd = 16'($urandom); be = 2'($urandom);
            op(we, wa, wd, be, re, ra, 1'b0);
            if (bus.rvalid !== re) bad_v++;
            if (bus.rdata !== mdl_rdata) begin
                bad_d++;
                if (bad_d <= 3) $display("FAIL random_rdata: cycle %0d rdata=%h want %h", i, bus.rdata, mdl_rdata);
            end
        end
        n_total++; if (bad_v != 0) $display("FAIL random_rvalid: %0d cycles rvalid wrong", bad_v); else n_pass++;
        n_total++; if (bad_d != 0) $display("FAIL random_data: %0d cycles rdata wrong", bad_d); else n_pass++;
    endtask

    initial begin
        mdl_rdata = 16'h0000;
        model_clear();
        test_reset();
        test_write_read();
        test_byte_enable();
        test_same_addr();
        test_clear();
        test_reset_mid_sweep();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
